// File: rtl/sram_controller.sv
// sram_controller: MEM-stage responder that turns one 32-bit word request into
// two 16-bit accesses on an external asynchronous SRAM. ready stays low until
// the word completes.
// Optional feature macro: SRAM_READ_BUFFER_EN (one-entry read buffer, write-through).
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   wr_en, rd_en         level requests, held until ready
//   address, write_data  CPU byte address and write word
//   read_data            last completed read word (registered)
//   ready                no request pending, or request completes this cycle
//   sram_addr            SRAM half-word address {word, half}
//   sram_dq_out/_in/_oe  pad data out, pad data in, pad output enable
//   sram_we_n            SRAM write strobe, active-low
module sram_controller #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_we_n
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WORD_W = 17;

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_wr_q, is_wr_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        read_data_q, read_data_d;
    logic [17:0]        addr_q, addr_d;
    logic [15:0]        dq_out_q, dq_out_d;
    logic               oe_q, oe_d;
    logic               we_n_q, we_n_d;

`ifdef SRAM_READ_BUFFER_EN
    logic               buf_valid_q, buf_valid_d;
    logic [WORD_W-1:0]  buf_tag_q, buf_tag_d;
    logic [31:0]        buf_data_q, buf_data_d;
    logic               hit;
`endif

    logic               req;
    logic               last;
    logic [WORD_W-1:0]  req_word;

    // Byte offset from BASE_ADDR (mod 2^32), word index is offset bits [18:2]
    assign req_word = WORD_W'((address - BASE_ADDR) >> 2);
    assign req      = wr_en | rd_en;
    assign last     = (cnt_q == CNT_W'(WAIT_CYCLES - 1));
    assign ready    = (state_q == DONE) | ((state_q == IDLE) & ~req);

`ifdef SRAM_READ_BUFFER_EN
    assign hit = rd_en & ~wr_en & buf_valid_q & (buf_tag_q == req_word);
`endif

    assign read_data   = read_data_q;
    assign sram_addr   = addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = oe_q;
    assign sram_we_n   = we_n_q;

    // Next-state and next-output logic; pad outputs are computed for the next state
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_wr_d     = is_wr_q;
        word_d      = word_q;
        wdata_d     = wdata_q;
        read_data_d = read_data_q;
        addr_d      = addr_q;
        dq_out_d    = dq_out_q;
        oe_d        = 1'b0;
        we_n_d      = 1'b1;
`ifdef SRAM_READ_BUFFER_EN
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_data_d  = buf_data_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    // A write wins over a simultaneous read
                    is_wr_d  = wr_en;
                    word_d   = req_word;
                    wdata_d  = write_data;
                    cnt_d    = '0;
                    state_d  = LOW;
                    addr_d   = {req_word, 1'b0};
                    dq_out_d = write_data[15:0];
                    oe_d     = wr_en;
                    we_n_d   = ~wr_en;
`ifdef SRAM_READ_BUFFER_EN
                    // Buffer hit skips the SRAM entirely
                    if (hit) begin
                        state_d     = DONE;
                        addr_d      = addr_q;
                        dq_out_d    = dq_out_q;
                        oe_d        = 1'b0;
                        we_n_d      = 1'b1;
                        read_data_d = buf_data_q;
                    end
`endif
                end
            end
            LOW: begin
                oe_d   = is_wr_q;
                we_n_d = ~is_wr_q;
                if (last) begin
                    state_d  = HIGH;
                    cnt_d    = '0;
                    addr_d   = {word_q, 1'b1};
                    dq_out_d = wdata_q[31:16];
                    if (!is_wr_q) read_data_d[15:0] = sram_dq_in;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HIGH: begin
                if (last) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    if (!is_wr_q) read_data_d[31:16] = sram_dq_in;
`ifdef SRAM_READ_BUFFER_EN
                    if (!is_wr_q) begin
                        buf_valid_d = 1'b1;
                        buf_tag_d   = word_q;
                        buf_data_d  = {sram_dq_in, read_data_q[15:0]};
                    end else if (buf_valid_q && (buf_tag_q == word_q)) begin
                        buf_data_d  = wdata_q;
                    end
`endif
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    oe_d   = is_wr_q;
                    we_n_d = ~is_wr_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            is_wr_q     <= 1'b0;
            word_q      <= '0;
            wdata_q     <= '0;
            read_data_q <= '0;
            addr_q      <= '0;
            dq_out_q    <= '0;
            oe_q        <= 1'b0;
            we_n_q      <= 1'b1;
`ifdef SRAM_READ_BUFFER_EN
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_wr_q     <= is_wr_d;
            word_q      <= word_d;
            wdata_q     <= wdata_d;
            read_data_q <= read_data_d;
            addr_q      <= addr_d;
            dq_out_q    <= dq_out_d;
            oe_q        <= oe_d;
            we_n_q      <= we_n_d;
`ifdef SRAM_READ_BUFFER_EN
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_data_q  <= buf_data_d;
`endif
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller (WAIT_CYCLES=2) with a behavioural async SRAM.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;

    int tests = 0;
    int fails = 0;

`ifdef SRAM_READ_BUFFER_EN
    localparam int HIT_CYC  = 1;
    localparam logic [31:0] B2B_MASK = 32'h0000_0AA0;
`else
    localparam int HIT_CYC  = 5;
    localparam logic [31:0] B2B_MASK = 32'h0000_0820;
`endif

    sram_controller #(.WAIT_CYCLES(2), .BASE_ADDR(32'd1024)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: asynchronous read, write while we_n is low
    logic [15:0] mem [0:262143];
    assign sram_dq_in = mem[sram_addr];
    always @(posedge clk) if (!sram_we_n) mem[sram_addr] <= sram_dq_out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request at cycle 0, run until ready (bounded), then drop it
    task automatic access(input logic wr, input logic rd, input logic [31:0] a,
                          input logic [31:0] d, output int rcyc,
                          output logic [17:0] a_first, output logic [17:0] a_last,
                          output int nwe);
        wr_en = wr; rd_en = rd; address = a; write_data = d;
        rcyc = -1; nwe = 0; a_first = sram_addr; a_last = sram_addr;
        #1;
        check("cycle0_ready", 32'(ready), 32'd0);
        for (int c = 1; c <= 40; c++) begin
            step();
            if (c == 1) a_first = sram_addr;
            if (!sram_we_n) nwe++;
            if (ready) begin
                rcyc = c;
                break;
            end
            a_last = sram_addr;
        end
        wr_en = 1'b0; rd_en = 1'b0;
        step();
    endtask

    int          rcyc, nwe;
    logic [17:0] af, al, pre;
    logic [31:0] mask;

    initial begin
        for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;

        // Reset state
        repeat (2) step();
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_oe", 32'(sram_dq_oe), 32'd0);
        check("rst_read_data", read_data, 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        rst = 1'b1;
        step();

        // Reset in the middle of a write
        wr_en = 1'b1; address = 32'd1024; write_data = 32'hDEADBEEF;
        step();
        check("mid_c1_we_n", 32'(sram_we_n), 32'd0);
        step();
        rst = 1'b0; wr_en = 1'b0;
        #1;
        check("mid_rst_we_n", 32'(sram_we_n), 32'd1);
        check("mid_rst_oe", 32'(sram_dq_oe), 32'd0);
        check("mid_rst_read_data", read_data, 32'd0);
        check("mid_rst_ready", 32'(ready), 32'd1);
        step();
        rst = 1'b1;
        step();

        // Write 0xDEADBEEF to 1024, cycle by cycle
        wr_en = 1'b1; address = 32'd1024; write_data = 32'hDEADBEEF;
        #1;
        check("w_c0_ready", 32'(ready), 32'd0);
        step();
        check("w_c1_addr", 32'(sram_addr), 32'd0);
        check("w_c1_dq", 32'(sram_dq_out), 32'h0000BEEF);
        check("w_c1_we_n", 32'(sram_we_n), 32'd0);
        check("w_c1_oe", 32'(sram_dq_oe), 32'd1);
        step();
        check("w_c2_ready", 32'(ready), 32'd0);
        step();
        check("w_c3_addr", 32'(sram_addr), 32'd1);
        check("w_c3_dq", 32'(sram_dq_out), 32'h0000DEAD);
        step();
        check("w_c4_ready", 32'(ready), 32'd0);
        step();
        check("w_c5_ready", 32'(ready), 32'd1);
        wr_en = 1'b0;
        step();
        check("w_c6_we_n", 32'(sram_we_n), 32'd1);
        check("w_c6_oe", 32'(sram_dq_oe), 32'd0);
        check("w_c6_ready", 32'(ready), 32'd1);

        // Read 1024 back
        access(1'b0, 1'b1, 32'd1024, 32'h0, rcyc, af, al, nwe);
        check("r_ready_cycle", 32'(rcyc), 32'd5);
        check("r_data", read_data, 32'hDEADBEEF);
        check("r_no_we", 32'(nwe), 32'd0);
        check("r_addr_lo", 32'(af), 32'd0);
        check("r_addr_hi", 32'(al), 32'd1);

        // Top of the mapped range
        access(1'b1, 1'b0, 32'd1024 + 32'h7FFFC, 32'hCAFEF00D, rcyc, af, al, nwe);
        check("map_ready_cycle", 32'(rcyc), 32'd5);
        check("map_addr_lo", 32'(af), 32'h3FFFE);
        check("map_addr_hi", 32'(al), 32'h3FFFF);
        check("map_we_cycles", 32'(nwe), 32'd4);
        access(1'b0, 1'b1, 32'd1024 + 32'h7FFFC, 32'h0, rcyc, af, al, nwe);
        check("map_read", read_data, 32'hCAFEF00D);

        // Address 1023 wraps to word 0x1FFFF
        access(1'b1, 1'b0, 32'd1023, 32'h11112222, rcyc, af, al, nwe);
        check("wrap_addr_lo", 32'(af), 32'h3FFFE);
        check("wrap_addr_hi", 32'(al), 32'h3FFFF);
        access(1'b0, 1'b1, 32'd1024 + 32'h7FFFC, 32'h0, rcyc, af, al, nwe);
        check("wrap_read", read_data, 32'h11112222);
        check("wrap_read_cycle", 32'(rcyc), 32'(HIT_CYC));

        // Write and read together: write wins, read_data untouched
        access(1'b1, 1'b1, 32'd1032, 32'h12345678, rcyc, af, al, nwe);
        check("both_ready_cycle", 32'(rcyc), 32'd5);
        check("both_addr_lo", 32'(af), 32'd4);
        check("both_addr_hi", 32'(al), 32'd5);
        check("both_we_cycles", 32'(nwe), 32'd4);
        check("both_read_data", read_data, 32'h11112222);
        check("both_mem_lo", 32'(mem[4]), 32'h00005678);
        check("both_mem_hi", 32'(mem[5]), 32'h00001234);

        // rd_en held across DONE starts another access
        rd_en = 1'b1; address = 32'd1024; mask = '0;
        #1;
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) step();
            if (ready) mask[c] = 1'b1;
        end
        rd_en = 1'b0;
        step();
        check("b2b_ready_mask", mask, B2B_MASK);
        check("b2b_data", read_data, 32'hDEADBEEF);

        // Repeat read of 1024 (buffer hit when the buffer is built in)
        pre = sram_addr;
        access(1'b0, 1'b1, 32'd1024, 32'h0, rcyc, af, al, nwe);
        check("rep_ready_cycle", 32'(rcyc), 32'(HIT_CYC));
        check("rep_data", read_data, 32'hDEADBEEF);
        check("rep_no_we", 32'(nwe), 32'd0);
`ifdef SRAM_READ_BUFFER_EN
        check("rep_addr_idle", 32'(af), 32'(pre));
`else
        check("rep_addr_lo", 32'(af), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
